traffic_cl_seq: RTL and testbench

Sequential half of the traffic-light controller. It owns the phase register, the phase timer and the cross-request sensor synchroniser. It drives `a_pad`..`e_pad` into the combinational next-phase logic and consumes that block's `f_pad` advance decision. It also decodes the registered phase into the two lamp outputs.

---
 rtl/traffic_cl_pkg.sv | 30 +++
 rtl/traffic_cl_timer.sv | 36 +++
 rtl/traffic_cl_seq.sv | 98 +++++++++
 tb/tb_traffic_cl_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_cl_pkg.sv
// Shared types for the traffic-light controller: Gray-coded phase enum,
// lamp encodings and the phase-advance order.
package traffic_cl_pkg;

  typedef enum logic [1:0] {
    MAIN_GO   = 2'b00,
    MAIN_STOP = 2'b01,
    SIDE_GO   = 2'b11,
    SIDE_STOP = 2'b10
  } phase_e;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  // Gray order: exactly one phase bit flips per advance.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = MAIN_GO;
    case (p)
      MAIN_GO:   n = MAIN_STOP;
      MAIN_STOP: n = SIDE_GO;
      SIDE_GO:   n = SIDE_STOP;
      SIDE_STOP: n = MAIN_GO;
      default:   n = MAIN_GO;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_cl_timer.sv
// Phase timer: counts cycles in the current phase, cleared on advance,
// saturating at LONG_CYCLES-1; short/long thresholds decoded from the count flops.
module traffic_cl_timer
  import traffic_cl_pkg::*;
#(
  parameter int SHORT_CYCLES = 3,
  parameter int LONG_CYCLES  = 8,
  parameter int TIMER_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic long_hit,
  output logic short_hit
);

  localparam logic [TIMER_W-1:0] LONG_MAX  = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHORT_MAX = TIMER_W'(SHORT_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  // Clear has priority over saturation so an advance always restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LONG_MAX) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign long_hit  = (count >= LONG_MAX);
  assign short_hit = (count >= SHORT_MAX);

endmodule

// File: rtl/traffic_cl_seq.sv
// Sequential half of the traffic-light controller: phase register, phase timer,
// sensor synchroniser and lamp decode. Macro TRAFFIC_CL_SEQ_SENSOR_SYNC_EN selects a 2-flop sensor sync.
module traffic_cl_seq
  import traffic_cl_pkg::*;
#(
  parameter int SHORT_CYCLES = 3,
  parameter int LONG_CYCLES  = 8,
  parameter int TIMER_W      = 4
) (
  input  logic       clk_pad,
  input  logic       rst_n_pad,
  input  logic       sensor_pad,
  input  logic       f_pad,
  output logic       a_pad,
  output logic       b_pad,
  output logic       c_pad,
  output logic       d_pad,
  output logic       e_pad,
  output logic [1:0] main_lamp,
  output logic [1:0] side_lamp
);

  phase_e phase_q;
  phase_e phase_d;

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      phase_q <= MAIN_GO;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (f_pad) begin
      phase_d = next_phase(phase_q);
    end
  end

  traffic_cl_timer #(
    .SHORT_CYCLES(SHORT_CYCLES),
    .LONG_CYCLES (LONG_CYCLES),
    .TIMER_W     (TIMER_W)
  ) u_timer (
    .clk      (clk_pad),
    .rst_n    (rst_n_pad),
    .clear    (f_pad),
    .long_hit (d_pad),
    .short_hit(e_pad)
  );

`ifdef TRAFFIC_CL_SEQ_SENSOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sensor_pad};
    end
  end

  assign c_pad = sync_q[1];
`else
  logic sync_q;

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sensor_pad;
    end
  end

  assign c_pad = sync_q;
`endif

  assign a_pad = phase_q[0];
  assign b_pad = phase_q[1];

  // Lamps decode the registered phase only, so at most one road is non-red.
  always_comb begin
    main_lamp = LAMP_RED;
    side_lamp = LAMP_RED;
    case (phase_q)
      MAIN_GO:   main_lamp = LAMP_GREEN;
      MAIN_STOP: main_lamp = LAMP_YELLOW;
      SIDE_GO:   side_lamp = LAMP_GREEN;
      SIDE_STOP: side_lamp = LAMP_YELLOW;
      default: begin
        main_lamp = LAMP_RED;
        side_lamp = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_cl_seq.sv
// Bench for traffic_cl_seq: directed vector table, phase-duration and reset
// sequences, and randomized run against a phase/cycle-count reference model.
module tb_traffic_cl_seq;

  localparam int SHORT = 3;
  localparam int LONG  = 8;
`ifdef TRAFFIC_CL_SEQ_SENSOR_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 1;
`endif

  logic       clk_pad = 1'b0;
  logic       rst_n_pad;
  logic       sensor_pad;
  logic       f_pad;
  logic       a_pad, b_pad, c_pad, d_pad, e_pad;
  logic [1:0] main_lamp, side_lamp;

  int errors = 0;
  int checks = 0;

  traffic_cl_seq #(
    .SHORT_CYCLES(SHORT),
    .LONG_CYCLES (LONG),
    .TIMER_W     (4)
  ) dut (
    .clk_pad   (clk_pad),
    .rst_n_pad (rst_n_pad),
    .sensor_pad(sensor_pad),
    .f_pad     (f_pad),
    .a_pad     (a_pad),
    .b_pad     (b_pad),
    .c_pad     (c_pad),
    .d_pad     (d_pad),
    .e_pad     (e_pad),
    .main_lamp (main_lamp),
    .side_lamp (side_lamp)
  );

  always #5 clk_pad = ~clk_pad;

  // Reference model: phase index in the road sequence, cycles spent in it,
  // and a FIFO of sensor samples as deep as the synchroniser.
  int   m_phase;
  int   m_cnt;
  logic m_sync[$];

  function automatic logic [1:0] phase_bits(input int idx);
    logic [1:0] tbl [4];
    tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b11; tbl[3] = 2'b10;
    return tbl[idx];
  endfunction

  function automatic logic [1:0] main_of(input int idx);
    logic [1:0] tbl [4];
    tbl[0] = 2'd2; tbl[1] = 2'd1; tbl[2] = 2'd0; tbl[3] = 2'd0;
    return tbl[idx];
  endfunction

  function automatic logic [1:0] side_of(input int idx);
    logic [1:0] tbl [4];
    tbl[0] = 2'd0; tbl[1] = 2'd0; tbl[2] = 2'd2; tbl[3] = 2'd1;
    return tbl[idx];
  endfunction

  function automatic logic [8:0] model_out();
    logic [1:0] ph;
    logic       c, d, e;
    ph = phase_bits(m_phase);
    c  = m_sync[0];
    d  = (m_cnt >= LONG - 1);
    e  = (m_cnt >= SHORT - 1);
    return {ph, c, d, e, main_of(m_phase), side_of(m_phase)};
  endfunction

  function automatic logic model_f();
    logic a, b, c, d, e;
    {b, a} = phase_bits(m_phase);
    c = m_sync[0];
    d = (m_cnt >= LONG - 1);
    e = (m_cnt >= SHORT - 1);
    return d | (a & b & c) | (e & a & b) | (e & c & (a | b));
  endfunction

  function automatic logic [8:0] dut_vec();
    return {b_pad, a_pad, c_pad, d_pad, e_pad, main_lamp, side_lamp};
  endfunction

  localparam logic [8:0] RESET_VEC = {2'b00, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_sync.delete();
    for (int i = 0; i < SYNC_D; i++) m_sync.push_back(1'b0);
  endtask

  // fmode: 0 model f, 1 force 0, 2 force 1, 3 random
  task automatic step(input logic sens, input int fmode);
    case (fmode)
      0:       f_pad = model_f();
      1:       f_pad = 1'b0;
      2:       f_pad = 1'b1;
      default: f_pad = 1'($urandom_range(0, 1));
    endcase
    sensor_pad = sens;
    @(posedge clk_pad);
    if (f_pad) begin
      m_phase = (m_phase + 1) % 4;
      m_cnt   = 0;
    end else if (m_cnt < LONG - 1) begin
      m_cnt++;
    end
    m_sync.push_back(sens);
    void'(m_sync.pop_front());
    @(negedge clk_pad);
    check("model", dut_vec(), model_out());
    check("lamp_excl", {8'd0, (main_lamp != 2'd0) && (side_lamp != 2'd0)}, 9'd0);
  endtask

  task automatic do_reset(input logic sens_after);
    rst_n_pad  = 1'b0;
    f_pad      = 1'b0;
    sensor_pad = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_pad);
    rst_n_pad  = 1'b1;
    sensor_pad = sens_after;
    check("post_reset", dut_vec(), RESET_VEC);
  endtask

  task automatic phase_len(input logic sens, output int n);
    logic [1:0] ph0;
    ph0 = {b_pad, a_pad};
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step(sens, 0);
      if ({b_pad, a_pad} != ph0) return;
      n++;
    end
  endtask

  typedef struct {
    logic       f;
    logic [1:0] ph;
    logic       e;
    logic       d;
    logic [1:0] ml;
    logic [1:0] sl;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic f, input logic [1:0] ph, input logic e,
                              input logic d, input logic [1:0] ml, input logic [1:0] sl);
    vec_t v;
    v.f = f; v.ph = ph; v.e = e; v.d = d; v.ml = ml; v.sl = sl;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bound;
    int edges;
    int exp_s1 [5];
    int exp_s0 [4];
    logic sens;

    // Expected state after each edge, from reset, sensor held 0.
    tbl[0]  = mk(0, 2'b00, 0, 0, 2'd2, 2'd0);
    tbl[1]  = mk(0, 2'b00, 1, 0, 2'd2, 2'd0);
    tbl[2]  = mk(0, 2'b00, 1, 0, 2'd2, 2'd0);
    tbl[3]  = mk(0, 2'b00, 1, 0, 2'd2, 2'd0);
    tbl[4]  = mk(0, 2'b00, 1, 0, 2'd2, 2'd0);
    tbl[5]  = mk(0, 2'b00, 1, 0, 2'd2, 2'd0);
    tbl[6]  = mk(0, 2'b00, 1, 1, 2'd2, 2'd0);
    tbl[7]  = mk(0, 2'b00, 1, 1, 2'd2, 2'd0);
    tbl[8]  = mk(0, 2'b00, 1, 1, 2'd2, 2'd0);
    tbl[9]  = mk(0, 2'b00, 1, 1, 2'd2, 2'd0);
    tbl[10] = mk(1, 2'b01, 0, 0, 2'd1, 2'd0);
    tbl[11] = mk(0, 2'b01, 0, 0, 2'd1, 2'd0);
    tbl[12] = mk(1, 2'b11, 0, 0, 2'd0, 2'd2);
    tbl[13] = mk(1, 2'b10, 0, 0, 2'd0, 2'd1);
    tbl[14] = mk(0, 2'b10, 0, 0, 2'd0, 2'd1);
    tbl[15] = mk(0, 2'b10, 1, 0, 2'd0, 2'd1);
    tbl[16] = mk(1, 2'b00, 0, 0, 2'd2, 2'd0);

    // Reset state
    rst_n_pad  = 1'b0;
    f_pad      = 1'b0;
    sensor_pad = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_pad);
    check("reset_state", dut_vec(), RESET_VEC);
    rst_n_pad = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      step(1'b0, tbl[i].f ? 2 : 1);
      check($sformatf("vec_%0d", i),
            {1'b0, b_pad, a_pad, e_pad, d_pad, main_lamp, side_lamp},
            {1'b0, tbl[i].ph, tbl[i].e, tbl[i].d, tbl[i].ml, tbl[i].sl});
    end

    // Saturation: f held low for 20 cycles in MAIN_GO
    do_reset(1'b0);
    repeat (20) step(1'b0, 1);
    check("saturate", {5'd0, b_pad, a_pad, d_pad, e_pad}, {5'd0, 2'b00, 1'b1, 1'b1});

    // Phase durations, sensor held 1: MAIN_GO, then one fast loop
    exp_s1[0] = 8; exp_s1[1] = 3; exp_s1[2] = 1; exp_s1[3] = 3; exp_s1[4] = 8;
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      phase_len(1'b1, n);
      check($sformatf("dur_s1_%0d", i), 9'(n), 9'(exp_s1[i]));
    end

    // Phase durations, sensor held 0
    exp_s0[0] = 8; exp_s0[1] = 8; exp_s0[2] = 3; exp_s0[3] = 8;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      phase_len(1'b0, n);
      check($sformatf("dur_s0_%0d", i), 9'(n), 9'(exp_s0[i]));
    end

    // Asynchronous reset in SIDE_GO with count 2
    do_reset(1'b0);
    bound = 0;
    while (!(m_phase == 2 && m_cnt == 2) && bound < 60) begin
      step(1'b0, 0);
      bound++;
    end
    check("reach_side_go", {8'd0, bound >= 60}, 9'd0);
    #2 rst_n_pad = 1'b0;
    model_reset();
    #1 check("async_reset", dut_vec(), RESET_VEC);
    f_pad      = 1'b1;
    sensor_pad = 1'b1;
    repeat (2) @(negedge clk_pad);
    check("reset_hold", dut_vec(), RESET_VEC);
    rst_n_pad  = 1'b1;
    f_pad      = 1'b0;
    sensor_pad = 1'b0;
    check("after_release", dut_vec(), RESET_VEC);
    repeat (3) step(1'b0, 0);

    // Sensor pulse latency
    edges = 1;
    step(1'b1, 0);
    while (!c_pad && edges < 5) begin
      step(1'b0, 0);
      edges++;
    end
    check("sensor_latency", 9'(edges), 9'(SYNC_D));

    // Randomized run against the model
    do_reset(1'b0);
    sens = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sens = ~sens;
      step(sens, ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
